// File: rtl/uart_irq_pkg.sv
// uart_irq_pkg
// Shared definitions for the UART interrupt controller:
//   - IIR[3:0] codes for each interrupt source and the idle code
//   - rx_trig_e : FCR RX trigger-level select encoding
//   - rx_trigger_threshold() : maps (trigger select, RX FIFO depth) to a fill threshold
package uart_irq_pkg;

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTI  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_MSI  = 4'b0000;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    typedef enum logic [1:0] {
        TRIG_ONE      = 2'b00,
        TRIG_QUARTER  = 2'b01,
        TRIG_HALF     = 2'b10,
        TRIG_DEPTH_M2 = 2'b11
    } rx_trig_e;

    // Trigger levels scale with the FIFO depth so the same FCR setting
    // keeps the same relative fill point for any RX_FIFO_DEPTH.
    function automatic int unsigned rx_trigger_threshold(input rx_trig_e    sel,
                                                         input int unsigned depth);
        int unsigned thr;
        case (sel)
            TRIG_ONE:     thr = 1;
            TRIG_QUARTER: thr = depth / 4;
            TRIG_HALF:    thr = depth / 2;
            default:      thr = depth - 2;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout
// Character-timeout (CTI) detector: counts character times of RX inactivity
// while the RX FIFO holds data and raises a pending flag after TIMEOUT_CHARS.
// Ports:
//   clk_i, rstn_i     : clock, asynchronous active-low reset
//   rx_push_i         : character written into the RX FIFO (pulse)
//   rx_pop_i          : RBR read (pulse)
//   rx_elements_i     : RX FIFO fill level
//   char_tick_i       : one pulse per character time
//   cti_pend_o        : CTI pending flag
//   cnt_o             : current idle character count (saturating)
module uart_rx_timeout #(
    parameter  int unsigned TIMEOUT_CHARS = 4,
    parameter  int unsigned RXW           = 6,
    localparam int unsigned CW            = $clog2(TIMEOUT_CHARS + 1)
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           rx_push_i,
    input  logic           rx_pop_i,
    input  logic [RXW-1:0] rx_elements_i,
    input  logic           char_tick_i,
    output logic           cti_pend_o,
    output logic [CW-1:0]  cnt_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CHARS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cti_q, cti_d;
    logic          rx_clr;

    always_comb begin
        rx_clr = rx_push_i | rx_pop_i | (rx_elements_i == '0);
        cnt_d  = cnt_q;
        if (rx_clr) begin
            cnt_d = '0;
        end else if (char_tick_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Flag is raised on the same edge the count reaches the limit;
        // any RX activity or an empty FIFO wins over the set.
        cti_d = rx_clr ? 1'b0 : (cti_q | (cnt_d == CNT_MAX));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            cti_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cti_q <= cti_d;
        end
    end

    assign cti_pend_o = cti_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl
// 16550-style interrupt controller: per-source pending flags (RLS, THRE,
// MSI, plus CTI from uart_rx_timeout), level RDA from the RX fill level,
// priority encoder and registered IIR / interrupt request.
// Ports:
//   clk_i, rstn_i      : clock, asynchronous active-low reset
//   ier_i              : [0] RDA/CTI, [1] THRE, [2] RLS, [3] MSI enables
//   fifo_en_i          : FCR FIFO enable (0 forces RX trigger level 1)
//   trigger_level_i    : RX trigger select
//   rx_elements_i      : RX FIFO fill level
//   tx_elements_i      : TX FIFO fill level
//   rx_push_i/rx_pop_i : RX FIFO write / RBR read pulses
//   thr_write_i        : THR write pulse
//   rx_error_i         : line error pulse
//   lsr_read_i         : LSR read strobe
//   msr_delta_i        : MSR delta bits (level)
//   msr_read_i         : MSR read strobe
//   iir_read_i         : IIR read strobe
//   char_tick_i        : character-time pulse
//   interrupt_o        : interrupt request
//   iir_o              : IIR[3:0]
//   timeout_o          : CTI pending flag
module uart_irq_ctrl
    import uart_irq_pkg::*;
#(
    parameter  int unsigned RX_FIFO_DEPTH = 32,
    parameter  int unsigned TX_FIFO_DEPTH = 32,
    parameter  int unsigned TIMEOUT_CHARS = 4,
    localparam int unsigned RXW           = $clog2(RX_FIFO_DEPTH) + 1,
    localparam int unsigned TXW           = $clog2(TX_FIFO_DEPTH) + 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [3:0]     ier_i,
    input  logic           fifo_en_i,
    input  logic [1:0]     trigger_level_i,
    input  logic [RXW-1:0] rx_elements_i,
    input  logic [TXW-1:0] tx_elements_i,
    input  logic           rx_push_i,
    input  logic           rx_pop_i,
    input  logic           thr_write_i,
    input  logic           rx_error_i,
    input  logic           lsr_read_i,
    input  logic [3:0]     msr_delta_i,
    input  logic           msr_read_i,
    input  logic           iir_read_i,
    input  logic           char_tick_i,
    output logic           interrupt_o,
    output logic [3:0]     iir_o,
    output logic           timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CHARS + 1);

    logic           rls_q, rls_d;
    logic           thre_q, thre_d;
    logic           msi_q, msi_d;
    logic           tx_empty_q, tx_empty_d;
    logic           ier_thre_q;
    logic [3:0]     iir_q, iir_d;
    logic           irq_q;
    logic [RXW-1:0] rx_thresh;
    logic           rda;
    logic           cti_pend;
    logic [CW-1:0]  rx_cnt;
    logic           thre_set, thre_clr;

    uart_rx_timeout #(
        .TIMEOUT_CHARS (TIMEOUT_CHARS),
        .RXW           (RXW)
    ) u_rx_timeout (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .rx_push_i     (rx_push_i),
        .rx_pop_i      (rx_pop_i),
        .rx_elements_i (rx_elements_i),
        .char_tick_i   (char_tick_i),
        .cti_pend_o    (cti_pend),
        .cnt_o         (rx_cnt)
    );

    always_comb begin
        rx_thresh = RXW'(1);
        if (fifo_en_i) begin
            rx_thresh = RXW'(rx_trigger_threshold(rx_trig_e'(trigger_level_i), RX_FIFO_DEPTH));
        end
        rda = (rx_elements_i >= rx_thresh);
    end

    always_comb begin
        tx_empty_d = (tx_elements_i == '0);
        // THRE rises when the TX FIFO drains, or when THRE gets enabled
        // while the FIFO is already empty.
        thre_set   = (tx_empty_d & ~tx_empty_q) | (ier_i[1] & ~ier_thre_q & tx_empty_q);
        // An IIR read only acknowledges THRE if THRE is what it returned.
        thre_clr   = thr_write_i | (iir_read_i & (iir_q == IIR_THRE));
        thre_d     = thre_set | (thre_q & ~thre_clr);
        rls_d      = rx_error_i | (rls_q & ~lsr_read_i);
        msi_d      = (|msr_delta_i) | (msi_q & ~msr_read_i);
    end

    always_comb begin
        iir_d = IIR_NONE;
        if (rls_q && ier_i[2]) begin
            iir_d = IIR_RLS;
        end else if (rda && ier_i[0]) begin
            iir_d = IIR_RDA;
        end else if (cti_pend && ier_i[0]) begin
            iir_d = IIR_CTI;
        end else if (thre_q && ier_i[1]) begin
            iir_d = IIR_THRE;
        end else if (msi_q && ier_i[3]) begin
            iir_d = IIR_MSI;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rls_q      <= 1'b0;
            thre_q     <= 1'b0;
            msi_q      <= 1'b0;
            tx_empty_q <= 1'b0;
            ier_thre_q <= 1'b0;
            iir_q      <= IIR_NONE;
            irq_q      <= 1'b0;
        end else begin
            rls_q      <= rls_d;
            thre_q     <= thre_d;
            msi_q      <= msi_d;
            tx_empty_q <= tx_empty_d;
            ier_thre_q <= ier_i[1];
            iir_q      <= iir_d;
            irq_q      <= ~iir_d[0];
        end
    end

    // The idle counter saturates at the timeout limit.
    cnt_bounded_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        rx_cnt <= CW'(TIMEOUT_CHARS));

    assign iir_o       = iir_q;
    assign interrupt_o = irq_q;
    assign timeout_o   = cti_pend;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb_uart_irq_ctrl
// Directed bench for uart_irq_ctrl with a cycle-level behavioural model of
// the interrupt rules and literal checkpoints along the test sequence.
module tb_uart_irq_ctrl;

    localparam int unsigned D = 32;
    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] ier = 4'b0010;
    logic       fifo_en = 1'b1;
    logic [1:0] trig = 2'b10;
    logic [5:0] rx_el = '0;
    logic [5:0] tx_el = '0;
    logic       rx_push = 1'b0, rx_pop = 1'b0, thr_write = 1'b0, rx_error = 1'b0;
    logic       lsr_read = 1'b0, msr_read = 1'b0, iir_read = 1'b0, char_tick = 1'b0;
    logic [3:0] msr_delta = '0;
    logic       irq;
    logic [3:0] iir;
    logic       tmo;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    uart_irq_ctrl #(
        .RX_FIFO_DEPTH (D),
        .TX_FIFO_DEPTH (32),
        .TIMEOUT_CHARS (T)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .ier_i           (ier),
        .fifo_en_i       (fifo_en),
        .trigger_level_i (trig),
        .rx_elements_i   (rx_el),
        .tx_elements_i   (tx_el),
        .rx_push_i       (rx_push),
        .rx_pop_i        (rx_pop),
        .thr_write_i     (thr_write),
        .rx_error_i      (rx_error),
        .lsr_read_i      (lsr_read),
        .msr_delta_i     (msr_delta),
        .msr_read_i      (msr_read),
        .iir_read_i      (iir_read),
        .char_tick_i     (char_tick),
        .interrupt_o     (irq),
        .iir_o           (iir),
        .timeout_o       (tmo)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] m_iir = 4'b0001;
    bit m_rls = 0, m_thre = 0, m_msi = 0, m_cti = 0;
    bit m_txe = 0, m_ier1 = 0;
    int m_idle = 0;
    bit m_rda, m_thre_set, m_thre_clr, m_rx_clr;

    function automatic logic [3:0] prio(bit rls, bit rda, bit cti, bit thre, bit msi,
                                        logic [3:0] en);
        bit         act  [5];
        logic [3:0] code [5];
        act  = '{rls & en[2], rda & en[0], cti & en[0], thre & en[1], msi & en[3]};
        code = '{4'b0110, 4'b0100, 4'b1100, 4'b0010, 4'b0000};
        for (int i = 0; i < 5; i++) if (act[i]) return code[i];
        return 4'b0001;
    endfunction

    function automatic int thresh(bit fen, logic [1:0] tl);
        if (!fen) return 1;
        case (tl)
            2'b00:   return 1;
            2'b01:   return D / 4;
            2'b10:   return D / 2;
            default: return D - 2;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_iir = 4'b0001;
            m_rls = 0; m_thre = 0; m_msi = 0; m_cti = 0;
            m_txe = 0; m_ier1 = 0; m_idle = 0;
        end else begin
            m_rda      = int'(rx_el) >= thresh(fifo_en, trig);
            m_thre_set = (tx_el == 0 && !m_txe) || (ier[1] && !m_ier1 && m_txe);
            m_thre_clr = thr_write || (iir_read && m_iir == 4'b0010);
            m_rx_clr   = rx_push || rx_pop || rx_el == 0;
            m_iir  = prio(m_rls, m_rda, m_cti, m_thre, m_msi, ier);
            m_rls  = rx_error || (m_rls && !lsr_read);
            m_thre = m_thre_set || (m_thre && !m_thre_clr);
            m_msi  = (msr_delta != 0) || (m_msi && !msr_read);
            if (m_rx_clr) begin
                m_idle = 0;
                m_cti  = 0;
            end else begin
                if (char_tick) m_idle++;
                if (m_idle >= T) m_cti = 1;
            end
            m_txe  = (tx_el == 0);
            m_ier1 = ier[1];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (iir !== m_iir) begin
                n_err++;
                $display("FAIL model_iir t=%0t iir_o=%b expected=%b", $time, iir, m_iir);
            end
            n_vec++;
            if (irq !== ~m_iir[0]) begin
                n_err++;
                $display("FAIL model_irq t=%0t interrupt_o=%b expected=%b", $time, irq, ~m_iir[0]);
            end
            n_vec++;
            if (tmo !== m_cti) begin
                n_err++;
                $display("FAIL model_cti t=%0t timeout_o=%b expected=%b", $time, tmo, m_cti);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk_bit(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b expected=%b", nm, got, exp);
        end
    endtask

    // Literal checkpoint: pins both the DUT and the model.
    task automatic chk_iir(input string nm, input logic [3:0] exp);
        n_vec++;
        if (iir !== exp) begin
            n_err++;
            $display("FAIL %s iir_o=%b expected=%b", nm, iir, exp);
        end
        n_vec++;
        if (m_iir !== exp) begin
            n_err++;
            $display("FAIL %s_model iir=%b expected=%b", nm, m_iir, exp);
        end
        chk_bit({nm, "_irq"}, irq, ~exp[0]);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        rx_push = 0; rx_pop = 0; thr_write = 0; rx_error = 0;
        lsr_read = 0; msr_read = 0; iir_read = 0; char_tick = 0;
        msr_delta = '0;
    endtask

    task automatic tick();
        char_tick = 1;
        cyc();
    endtask

    typedef struct {
        bit         fen;
        logic [1:0] tl;
        logic [5:0] el;
        logic [3:0] exp;
    } trig_vec_t;

    trig_vec_t tv[$] = '{
        '{1'b1, 2'b11, 6'd29, 4'b0001},
        '{1'b1, 2'b11, 6'd30, 4'b0100},
        '{1'b1, 2'b01, 6'd7,  4'b0001},
        '{1'b1, 2'b01, 6'd8,  4'b0100},
        '{1'b1, 2'b00, 6'd1,  4'b0100},
        '{1'b0, 2'b11, 6'd1,  4'b0100},
        '{1'b1, 2'b10, 6'd0,  4'b0001}
    };

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset with an empty TX FIFO and THRE enabled
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc();
        chk_iir("in_reset", 4'b0001);
        rstn = 1'b1;
        cyc();
        chk_iir("thre_1cyc", 4'b0001);
        cyc();
        chk_iir("thre_after_reset", 4'b0010);
        thr_write = 1; cyc(); cyc();
        chk_iir("thr_write_clear", 4'b0001);

        // RX trigger level
        ier = 4'b0001; fifo_en = 1; trig = 2'b10;
        rx_el = 15; cyc();
        chk_iir("rda_fill15", 4'b0001);
        rx_el = 16; cyc();
        chk_iir("rda_fill16", 4'b0100);
        rx_el = 15; rx_pop = 1; cyc();
        chk_iir("rda_pop15", 4'b0001);
        foreach (tv[i]) begin
            fifo_en = tv[i].fen; trig = tv[i].tl; rx_el = tv[i].el;
            cyc();
            chk_iir($sformatf("trig_%0d", i), tv[i].exp);
        end
        fifo_en = 1; trig = 2'b10;

        // Priority and RLS clear
        ier = 4'b0101; rx_el = 16; cyc();
        chk_iir("prio_rda", 4'b0100);
        rx_error = 1; cyc(); cyc();
        chk_iir("rls_set", 4'b0110);
        lsr_read = 1; cyc(); cyc();
        chk_iir("rls_clear", 4'b0100);
        rx_error = 1; lsr_read = 1; cyc(); cyc();
        chk_iir("rls_set_wins", 4'b0110);
        lsr_read = 1; cyc(); cyc();
        chk_iir("rls_clear2", 4'b0100);
        rx_el = 0; cyc(); cyc();

        // Character timeout
        ier = 4'b0001; rx_el = 3; cyc();
        tick(); tick(); tick(); cyc();
        chk_iir("cti_3ticks", 4'b0001);
        tick();
        chk_bit("cti_flag", tmo, 1'b1);
        cyc();
        chk_iir("cti_4ticks", 4'b1100);
        rx_pop = 1; rx_el = 2; cyc();
        chk_bit("cti_cnt_cleared", (dut.rx_cnt == 0), 1'b1);
        cyc();
        chk_iir("cti_pop", 4'b0001);
        tick(); tick();
        rx_push = 1; rx_el = 3; cyc();
        tick(); tick(); tick(); cyc();
        chk_iir("cti_restart", 4'b0001);
        tick(); cyc();
        chk_iir("cti_after_restart", 4'b1100);
        rx_el = 0; cyc(); cyc();

        // THRE IIR-read clear, with and without MSI
        ier = 4'b1000; tx_el = 1; cyc(); cyc();
        tx_el = 0; cyc(); cyc();
        chk_iir("thre_masked", 4'b0001);
        ier = 4'b1010; cyc();
        chk_iir("thre_unmasked", 4'b0010);
        iir_read = 1; cyc(); cyc();
        chk_iir("thre_iir_read", 4'b0001);
        ier = 4'b1000; cyc();
        ier = 4'b1010; msr_delta = 4'b0001; cyc(); cyc();
        chk_iir("thre_msi", 4'b0010);
        iir_read = 1; cyc(); cyc();
        chk_iir("msi_after_read", 4'b0000);
        msr_read = 1; cyc(); cyc();
        chk_iir("msi_clear", 4'b0001);

        // Masking with all sources pending
        ier = 4'b0000; rx_el = 16; rx_error = 1; msr_delta = 4'b0100; tx_el = 1; cyc();
        tx_el = 0; cyc();
        tick(); tick(); tick(); tick(); cyc();
        chk_iir("all_masked", 4'b0001);
        ier = 4'b1000; cyc();
        chk_iir("unmask_msi", 4'b0000);
        ier = 4'b1111; cyc();
        chk_iir("unmask_all", 4'b0110);
        lsr_read = 1; cyc(); cyc();
        chk_iir("all_rls_cleared", 4'b0100);

        // Asynchronous reset mid-operation
        rstn = 1'b0;
        #1;
        chk_iir("async_reset", 4'b0001);
        chk_bit("async_reset_tmo", tmo, 1'b0);
        cyc();
        rstn = 1'b1;
        cyc(); cyc(); cyc();
        chk_iir("post_reset_rda", 4'b0100);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
